// File: rtl/fetch_top.sv
// fetch_top: in-order instruction fetch with request throttling, response FIFO and redirect flush
// Parameters: RST_PC (PC after reset), BUF_DEPTH (FIFO entries, power of 2, 2..8)
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   o_imem_req_vld/addr    fetch request to instruction memory (word aligned)
//   i_imem_req_rdy         memory accepts the request
//   i_imem_rsp_vld/dat     in-order instruction response
//   i_ex_redir_vld/pc      redirect from execute
//   i_id_rdy               decode accepts the presented instruction
//   o_if_vld/inst/pc       instruction and its PC presented to decode
// Option: define FETCH_MISALIGN_EXC_EN to add o_if_misalign, which flags the
//   entry fetched after a redirect to a non-word-aligned target (its inst forced to NOP)
module fetch_top #(
    parameter logic [31:0] RST_PC    = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        o_imem_req_vld,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_rdy,
    input  logic        i_imem_rsp_vld,
    input  logic [31:0] i_imem_rsp_dat,
    input  logic        i_ex_redir_vld,
    input  logic [31:0] i_ex_redir_pc,
    input  logic        i_id_rdy,
    output logic        o_if_vld,
    output logic [31:0] o_if_inst,
    output logic [31:0] o_if_pc
`ifdef FETCH_MISALIGN_EXC_EN
    ,
    output logic        o_if_misalign
`endif
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(BUF_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {RUN, FLUSH} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]   r_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_stale;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [31:0]   r_buf_inst [BUF_DEPTH];
    logic [31:0]   r_buf_pc   [BUF_DEPTH];

    logic          w_req_vld;
    logic          w_acc;
    logic          w_rsp_stale;
    logic          w_push;
    logic          w_pop;
    logic [CW:0]   w_used;
    logic [CW-1:0] w_inflight;
    logic [31:0]   w_redir_pc;

    assign w_redir_pc  = i_ex_redir_pc & ~32'h3;
    assign w_used      = {1'b0, r_out} + {1'b0, r_cnt};
    assign w_acc       = w_req_vld & i_imem_req_rdy;
    assign w_rsp_stale = r_stale != '0;
    assign w_push      = i_imem_rsp_vld & ~w_rsp_stale & ~i_ex_redir_vld;
    assign w_pop       = o_if_vld & i_id_rdy & ~i_ex_redir_vld;
    // Requests still in flight after this cycle's response; only one of
    // r_stale/r_out is ever non-zero, so the sum is the whole in-flight set.
    assign w_inflight  = r_stale + r_out - CW'(i_imem_rsp_vld);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RUN;
        else r_state <= w_state_nxt;
    end

    // Request is gated by rst_n so nothing is issued while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_req_vld   = 1'b0;
        if (r_state == RUN) begin
            w_req_vld   = rst_n && !i_ex_redir_vld && (w_used < DEPTH_W);
            w_state_nxt = (i_ex_redir_vld && w_inflight != '0) ? FLUSH : RUN;
        end else begin
            w_state_nxt = (w_inflight == '0) ? RUN : FLUSH;
        end
    end

    // r_rsp_pc tracks the PC of the next non-stale response: responses are
    // in order and follow the fetch PC sequence since the last redirect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= RST_PC;
            r_rsp_pc <= RST_PC;
            r_out    <= '0;
            r_stale  <= '0;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else if (i_ex_redir_vld) begin
            r_pc     <= w_redir_pc;
            r_rsp_pc <= w_redir_pc;
            r_out    <= '0;
            r_stale  <= w_inflight;
            r_cnt    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            r_pc     <= w_acc ? r_pc + 32'd4 : r_pc;
            r_rsp_pc <= w_push ? r_rsp_pc + 32'd4 : r_rsp_pc;
            r_out    <= r_out + CW'(w_acc) - CW'(i_imem_rsp_vld & ~w_rsp_stale);
            r_stale  <= r_stale - CW'(i_imem_rsp_vld & w_rsp_stale);
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_pop);
            r_wptr   <= w_push ? r_wptr + AW'(1) : r_wptr;
            r_rptr   <= w_pop ? r_rptr + AW'(1) : r_rptr;
        end
    end

`ifdef FETCH_MISALIGN_EXC_EN
    logic r_mis_pend;
    logic r_buf_mis [BUF_DEPTH];

    // Set by a misaligned redirect; consumed by the first entry fetched after it.
    always_ff @(posedge clk) begin
        if (!rst_n) r_mis_pend <= 1'b0;
        else if (i_ex_redir_vld) r_mis_pend <= i_ex_redir_pc[1:0] != 2'b00;
        else if (w_push) r_mis_pend <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]   <= r_rsp_pc;
            r_buf_inst[r_wptr] <= r_mis_pend ? NOP : i_imem_rsp_dat;
            r_buf_mis[r_wptr]  <= r_mis_pend;
        end
    end

    assign o_if_misalign = o_if_vld & r_buf_mis[r_rptr];
`else
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wptr]   <= r_rsp_pc;
            r_buf_inst[r_wptr] <= i_imem_rsp_dat;
        end
    end
`endif

    assign o_imem_req_vld  = w_req_vld;
    assign o_imem_req_addr = r_pc;
    assign o_if_vld        = r_cnt != '0;
    assign o_if_inst       = o_if_vld ? r_buf_inst[r_rptr] : NOP;
    assign o_if_pc         = o_if_vld ? r_buf_pc[r_rptr] : 32'h0;
endmodule

// File: tb/tb_fetch_top.sv
// tb_fetch_top: randomized scoreboard bench for fetch_top against an instruction-stream model
module tb_fetch_top;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int RAND_END = 3000;
    localparam int DRAIN_END = 3040;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_vld, req_rdy, rsp_vld, redir_vld, id_rdy, if_vld, if_mis;
    logic [31:0] req_addr, rsp_dat, redir_pc, if_inst, if_pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gen = 0;
    int pops = 0;
    bit deliver_cur = 1'b0;
    logic [31:0] exp_req = RST_PC;
    logic mis_pend = 1'b0;

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic mis; } exp_t;
    typedef struct { logic [31:0] addr; int due; int gen; } mreq_t;
    exp_t  sb[$];
    mreq_t mq[$];

    always #5 clk = ~clk;

    fetch_top #(.RST_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .o_imem_req_vld(req_vld),
        .o_imem_req_addr(req_addr),
        .i_imem_req_rdy(req_rdy),
        .i_imem_rsp_vld(rsp_vld),
        .i_imem_rsp_dat(rsp_dat),
        .i_ex_redir_vld(redir_vld),
        .i_ex_redir_pc(redir_pc),
        .i_id_rdy(id_rdy),
        .o_if_vld(if_vld),
        .o_if_inst(if_inst),
        .o_if_pc(if_pc)
`ifdef FETCH_MISALIGN_EXC_EN
        ,
        .o_if_misalign(if_mis)
`endif
    );
`ifndef FETCH_MISALIGN_EXC_EN
    assign if_mis = 1'b0;
`endif

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h9E37_79B9;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Stimulus and memory model: drives inputs at negedge, settles, then
    // accounts for this cycle's request acceptance.
    initial begin
        int rst_left = 0;
        int rdy_stall = 0;
        int id_stall = 0;
        int lat = 1;
        int stale = 0;
        bit in_rst, first, redir;
        bit rst_prev = 1'b1;
        bit done35 = 1'b0;
        bit prev_stall = 1'b0;
        logic [31:0] tgt;
        logic [31:0] prev_addr = '0;
        req_rdy = 1'b0; rsp_vld = 1'b0; rsp_dat = '0; redir_vld = 1'b0; redir_pc = '0; id_rdy = 1'b0;
        while (cyc < DRAIN_END) begin
            @(negedge clk);
            redir = 1'b0; tgt = '0; lat = 1; req_rdy = 1'b1; id_rdy = 1'b1; in_rst = 1'b0;
            if (cyc < 3) in_rst = 1'b1;
            else if (cyc < 43) begin end
            else if (cyc < 63) id_rdy = !(cyc >= 45 && cyc < 55);
            else if (cyc < 83) req_rdy = !(cyc >= 65 && cyc < 70);
            else if (cyc < 103) begin
                lat = 3;
                if (!done35 && cyc >= 90 && mq.size() == 2) begin redir = 1'b1; tgt = 32'h100; done35 = 1'b1; end
            end else if (cyc < 123) begin
                lat = 2;
                if (cyc == 106) begin redir = 1'b1; tgt = 32'hFFFF_FFF8; end
            end else if (cyc < 150) begin
                lat = 4;
                redir = (cyc == 126) || (cyc == 140);
                tgt = (cyc == 126) ? 32'h102 : 32'h200;
                in_rst = (cyc == 141) || (cyc == 142);
            end else if (cyc < RAND_END) begin
                lat = $urandom_range(1, 4);
                if (rdy_stall > 0) rdy_stall--;
                else if ($urandom_range(0, 29) == 0) rdy_stall = $urandom_range(3, 8);
                if (id_stall > 0) id_stall--;
                else if ($urandom_range(0, 29) == 0) id_stall = $urandom_range(5, 12);
                req_rdy = rdy_stall == 0 && $urandom_range(0, 3) != 0;
                id_rdy = id_stall == 0 && $urandom_range(0, 3) != 0;
                if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 2);
                if (rst_left > 0) begin in_rst = 1'b1; rst_left--; end
                redir = $urandom_range(0, 19) == 0;
                tgt = $urandom & 32'h0000_3FFC;
                if ($urandom_range(0, 7) == 0) tgt = {27'h7FF_FFFF, tgt[4:0]};
                if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            end else req_rdy = cyc < RAND_END + 20;
            first = !in_rst && rst_prev;
            if (in_rst || first) redir = 1'b0;
            rst_n = !in_rst;
            redir_vld = redir;
            redir_pc = tgt;
            rsp_vld = 1'b0; rsp_dat = '0; deliver_cur = 1'b0;
            if (in_rst) begin
                mq.delete(); sb.delete(); gen++; exp_req = RST_PC; mis_pend = 1'b0;
            end else begin
                if (redir) begin
                    gen++; sb.delete(); exp_req = tgt & ~32'h3;
`ifdef FETCH_MISALIGN_EXC_EN
                    mis_pend = tgt[1:0] != 2'b00;
`endif
                end
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    rsp_vld = 1'b1; rsp_dat = mem_word(mq[0].addr); deliver_cur = mq[0].gen == gen;
                end
            end
            #1;
            if (in_rst) check("rst_req_vld", req_vld, 0);
            else begin
                if (rsp_vld) void'(mq.pop_front());
                if (redir) check("redir_no_req", req_vld, 0);
                if (first) begin
                    check("first_req_vld", req_vld, 1);
                    check("first_req_addr", req_addr, RST_PC);
                end
                if (prev_stall && !redir) begin
                    check("held_vld", req_vld, 1);
                    check("held_addr", req_addr, prev_addr);
                end
                if (cyc == 4) check("if_vld_c1", if_vld, 0);
                if (cyc == 5) check("if_vld_c2", if_vld, 1);
                if (cyc == 53) check("stall_no_req", req_vld, 0);
                if (req_vld && req_rdy) begin
                    stale = 0;
                    foreach (mq[i]) if (mq[i].gen != gen) stale++;
                    check("req_addr", req_addr, exp_req);
                    check("req_in_flush", stale, 0);
                    mq.push_back('{addr: exp_req,
                                   due: (mq.size() > 0 && mq[$].due >= cyc + lat) ? mq[$].due + 1 : cyc + lat,
                                   gen: gen});
                    sb.push_back('{pc: exp_req, inst: mis_pend ? NOP : mem_word(exp_req), mis: mis_pend});
                    mis_pend = 1'b0;
                    exp_req += 32'd4;
                    check("outstanding_le_depth", mq.size() <= DEPTH, 1);
                end
            end
            prev_stall = !in_rst && req_vld && !req_rdy;
            prev_addr = req_addr;
            rst_prev = in_rst;
            cyc++;
        end
        @(negedge clk);
        #3;
        check("sb_drained", sb.size(), 0);
        check("mq_drained", mq.size(), 0);
        check("pops_enough", pops > 200, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: compares every instruction handed to decode against the scoreboard.
    initial begin
        exp_t e;
        bit prev_rst = 1'b0;
        bit prev_redir = 1'b0;
        bit prev_deliver = 1'b0;
        bit prev_hold = 1'b0;
        logic [31:0] prev_inst = '0;
        logic [31:0] prev_pc = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                if (prev_rst) begin
                    check("rst_if_vld", if_vld, 0);
                    check("rst_if_inst", if_inst, NOP);
                    check("rst_if_pc", if_pc, 0);
                end
            end else begin
                if (prev_rst) check("post_rst_if_vld", if_vld, 0);
                if (prev_redir) check("redir_flush_vld", if_vld, 0);
                if (prev_deliver) check("rsp_to_vld", if_vld, 1);
                if (prev_hold) begin
                    check("hold_vld", if_vld, 1);
                    check("hold_inst", if_inst, prev_inst);
                    check("hold_pc", if_pc, prev_pc);
                end
                if (!if_vld) begin
                    check("idle_inst", if_inst, NOP);
                    check("idle_pc", if_pc, 0);
                    check("idle_mis", if_mis, 0);
                end else if (id_rdy && !redir_vld) begin
                    pops++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_unexpected: got pc %0h want none (cycle %0d)", if_pc, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("if_pc", if_pc, e.pc);
                        check("if_inst", if_inst, e.inst);
`ifdef FETCH_MISALIGN_EXC_EN
                        check("if_misalign", if_mis, e.mis);
`endif
                    end
                end
            end
            prev_rst = !rst_n;
            prev_redir = rst_n && redir_vld;
            prev_deliver = deliver_cur;
            prev_hold = rst_n && if_vld && !id_rdy && !redir_vld;
            prev_inst = if_inst;
            prev_pc = if_pc;
        end
    end
endmodule

// File: doc/fetch_top.md
FETCH_TOP -- requirements
Module: fetch_top

Interface
REQ-001 SHALL have parameter RST_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries (power of 2, 2..8).
REQ-003 SHALL have `clk  input  1  clock signal`; single clock domain, all state on rising edge.
REQ-004 SHALL have `rst_n  input  1  reset, synchronous, active low`.
REQ-005 SHALL have `imem_req_vld  output  1  instruction fetch request valid`.
REQ-006 SHALL have `imem_req_addr  output  32  fetch byte address`, always word aligned.
REQ-007 SHALL have `imem_req_rdy  input  1  memory accepts request`.
REQ-008 SHALL have `imem_rsp_vld  input  1  response valid`; responses return in order, latency >= 1 cycle, never back-pressured.
REQ-009 SHALL have `imem_rsp_dat  input  32  response instruction word`.
REQ-010 SHALL have `ex_redir_vld  input  1  redirect (taken branch/jump) from execute`.
REQ-011 SHALL have `ex_redir_pc  input  32  redirect target`.
REQ-012 SHALL have `id_rdy  input  1  decode accepts instruction`.
REQ-013 SHALL have `if_vld  output  1  if_inst/if_pc valid`.
REQ-014 SHALL have `if_inst  output  32  instruction to decode`.
REQ-015 SHALL have `if_pc  output  32  PC of if_inst`.

Function
REQ-016 SHALL issue a request when state is RUN and outstanding + buffered < BUF_DEPTH; a request is accepted when imem_req_vld & imem_req_rdy.
REQ-017 SHALL hold imem_req_addr stable while imem_req_vld=1 and imem_req_rdy=0; fetch PC advances by 4 only on acceptance, wrapping 32'hFFFF_FFFC -> 0.
REQ-018 SHALL count outstanding requests (+1 on accept, -1 on response, both same cycle = no change), never exceeding BUF_DEPTH.
REQ-019 SHALL push each non-stale response with its PC into a FIFO of BUF_DEPTH entries; FIFO never overflows because of REQ-016.
REQ-020 SHALL present FIFO head on if_inst/if_pc with if_vld=1 when non-empty, and pop when if_vld & id_rdy.
REQ-021 SHALL drive if_inst=32'h0000_0013 (NOP), if_pc=0 and if_vld=0 when empty.
REQ-022 SHALL bypass nothing: minimum response-to-if_vld latency is 1 cycle (registered FIFO write).
REQ-023 SHALL implement FSM states RUN and FLUSH.
REQ-024 On ex_redir_vld: SHALL flush FIFO, set fetch PC = {ex_redir_pc[31:2],2'b00}, suppress the request in that cycle, mark all outstanding requests (after that cycle's accept/response update) as stale, go to FLUSH if stale > 0 else stay in RUN.
REQ-025 In FLUSH: SHALL issue no requests, discard responses decrementing stale count, return to RUN in the cycle after the count reaches 0.
REQ-026 A redirect in FLUSH SHALL update the fetch PC and keep the existing stale count.
REQ-027 Redirect and pop in the same cycle SHALL resolve as redirect (FIFO emptied, if_vld=0 next cycle).

Reset
REQ-028 With rst_n=0 at a clock edge: fetch PC=RST_PC, FIFO empty, outstanding=stale=0, state=RUN, imem_req_vld=0, if_vld=0, if_inst=NOP, if_pc=0.
REQ-029 Reset mid-operation SHALL abandon in-flight requests; responses arriving after reset deasserts belong to the environment, which SHALL not return them.
REQ-030 First request SHALL be issued in the first cycle with rst_n=1, at address RST_PC.

Configuration
REQ-031 Macro FETCH_MISALIGN_EXC_EN: when defined, SHALL add output `if_misalign  1` asserted with if_vld for the entry produced by a redirect whose ex_redir_pc[1:0]!=0, its if_inst forced to NOP; when undefined, port absent and low bits silently cleared per REQ-024.

Verification
REQ-032 Reset, rst_n=1, imem_req_rdy=1, 1-cycle response, id_rdy=1 -> requests 0x0,0x4,0x8…; if_vld from cycle 2, if_pc increments by 4 each cycle.
REQ-033 id_rdy=0 for 10 cycles -> at most BUF_DEPTH=2 outstanding+buffered, imem_req_vld=0 after fill, if_inst/if_pc stable, no word lost on release.
REQ-034 imem_req_rdy=0 for 5 cycles -> imem_req_vld=1, imem_req_addr held constant, no PC advance.
REQ-035 Redirect to 0x100 with 2 outstanding (latency 3) -> FLUSH, both stale responses dropped, next request addr 0x100, first if_pc=0x100.
REQ-036 Redirect and pop same cycle, plus rst_n=0 mid-FLUSH -> if_vld=0 next cycle; after reset first request at RST_PC, state RUN.
REQ-037 With FETCH_MISALIGN_EXC_EN, redirect to 0x102 -> request 0x100, if_misalign=1, if_inst=32'h0000_0013.
